// File: rtl/fault_detect_chklive_ts.sv
// fault_detect_chklive_ts
//   VRM fault detector for a power sequencer. Each rail is watched for:
//     - droop:   pgood lost while the rail's chklive window is open (or while
//                critical_fail is high), filtered over FILTER_CNT cycles
//     - timeout: pgood not reached within PG_TIMEOUT cycles of enable
//   The first capture cycle latches per-rail flags, their class and the
//   lowest failing rail index. Everything is held until fault_clear.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   vrm_enable[N]       rail enable
//   vrm_pgood[N]        rail power good (synchronous to clk)
//   vrm_chklive_en[N]   open the droop-check window
//   vrm_chklive_dis[N]  close the droop-check window (wins over en)
//   critical_fail       monitor all rails, bypass the droop filter
//   fault_clear         clear flags, counters and first-fault capture
//   lock                block new fault capture
//   vrm_fault[N]        per-rail fault flag
//   vrm_fault_tmo[N]    fault class (1 = timeout, 0 = droop)
//   any_vrm_fault       OR of vrm_fault
//   first_fault_valid   first-fault capture holds data
//   first_fault_idx     index of the first failing rail
//   first_fault_tmo     class of the first fault
module fault_detect_chklive_ts #(
  parameter int unsigned NUMBER_OF_VRM = 1,
  parameter int unsigned FILTER_CNT    = 4,
  parameter int unsigned PG_TIMEOUT    = 1000,
  parameter int unsigned TMO_W         = 16,
  parameter int unsigned IDX_W         = (NUMBER_OF_VRM > 1) ? $clog2(NUMBER_OF_VRM) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUMBER_OF_VRM-1:0] vrm_enable,
  input  logic [NUMBER_OF_VRM-1:0] vrm_pgood,
  input  logic [NUMBER_OF_VRM-1:0] vrm_chklive_en,
  input  logic [NUMBER_OF_VRM-1:0] vrm_chklive_dis,
  input  logic                     critical_fail,
  input  logic                     fault_clear,
  input  logic                     lock,
  output logic [NUMBER_OF_VRM-1:0] vrm_fault,
  output logic [NUMBER_OF_VRM-1:0] vrm_fault_tmo,
  output logic                     any_vrm_fault,
  output logic                     first_fault_valid,
  output logic [IDX_W-1:0]         first_fault_idx,
  output logic                     first_fault_tmo
);

  localparam int unsigned CNT_W = $clog2(FILTER_CNT + 1);

  // Filter count reaches LOW_LAST on the FILTER_CNT-th bad cycle, then
  // saturates at LOW_MAX so a long droop produces exactly one event.
  localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(FILTER_CNT - 1);
  localparam logic [CNT_W-1:0] LOW_MAX  = CNT_W'(FILTER_CNT);

  // Same scheme for the ramp timer.
  localparam logic [TMO_W-1:0] TMR_LAST = (PG_TIMEOUT == 0) ? '0 : TMO_W'(PG_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMR_MAX  = TMO_W'(PG_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_UP   = 2'd2
  } rail_st_e;

  // Per-rail state
  logic     [NUMBER_OF_VRM-1:0] chk_q, chk_d;
  rail_st_e                     st_q     [NUMBER_OF_VRM];
  rail_st_e                     st_d     [NUMBER_OF_VRM];
  logic     [CNT_W-1:0]         lowcnt_q [NUMBER_OF_VRM];
  logic     [CNT_W-1:0]         lowcnt_d [NUMBER_OF_VRM];
  logic     [TMO_W-1:0]         tmr_q    [NUMBER_OF_VRM];
  logic     [TMO_W-1:0]         tmr_d    [NUMBER_OF_VRM];

  // Per-rail combinational conditions
  logic [NUMBER_OF_VRM-1:0] monitor_en;
  logic [NUMBER_OF_VRM-1:0] bad;
  logic [NUMBER_OF_VRM-1:0] droop_evt;
  logic [NUMBER_OF_VRM-1:0] tmo_evt;
  logic [NUMBER_OF_VRM-1:0] cap;

  // Latched fault information
  logic [NUMBER_OF_VRM-1:0] fault_q, fault_d;
  logic [NUMBER_OF_VRM-1:0] fault_tmo_q, fault_tmo_d;
  logic                     any_q, any_d;
  logic                     ffv_q, ffv_d;
  logic [IDX_W-1:0]         ffi_q, ffi_d;
  logic                     fft_q, fft_d;
  logic                     lock_en;
  logic                     found;

  // Rail window, droop filter and ramp timer
  always_comb begin
    chk_d      = chk_q;
    monitor_en = '0;
    bad        = '0;
    droop_evt  = '0;
    tmo_evt    = '0;
    for (int unsigned i = 0; i < NUMBER_OF_VRM; i++) begin
      st_d[i]     = st_q[i];
      tmr_d[i]    = tmr_q[i];
      lowcnt_d[i] = lowcnt_q[i];

      if (vrm_chklive_dis[i]) begin
        chk_d[i] = 1'b0;
      end else if (vrm_chklive_en[i]) begin
        chk_d[i] = 1'b1;
      end

      monitor_en[i] = chk_q[i] | critical_fail;
      bad[i]        = vrm_enable[i] & ~vrm_pgood[i] & monitor_en[i];
      droop_evt[i]  = bad[i] & ((lowcnt_q[i] == LOW_LAST) | critical_fail);
      tmo_evt[i]    = (PG_TIMEOUT != 0) && (st_q[i] == ST_RAMP) &&
                      !vrm_pgood[i] && (tmr_q[i] == TMR_LAST);

      if (fault_clear || !bad[i]) begin
        lowcnt_d[i] = '0;
      end else if (lowcnt_q[i] != LOW_MAX) begin
        lowcnt_d[i] = lowcnt_q[i] + CNT_W'(1);
      end

      if (!vrm_enable[i]) begin
        st_d[i]  = ST_IDLE;
        tmr_d[i] = '0;
      end else begin
        case (st_q[i])
          ST_IDLE: begin
            st_d[i]  = ST_RAMP;
            tmr_d[i] = '0;
          end
          ST_RAMP: begin
            if (vrm_pgood[i]) begin
              st_d[i]  = ST_UP;
              tmr_d[i] = '0;
            end else if (tmr_q[i] != TMR_MAX) begin
              tmr_d[i] = tmr_q[i] + TMO_W'(1);
            end
          end
          ST_UP:   st_d[i] = ST_UP;
          default: st_d[i] = ST_IDLE;
        endcase
      end

      // A rail left in RAMP keeps ramping but restarts its timeout window.
      if (fault_clear) begin
        tmr_d[i] = '0;
      end
    end
  end

  // Fault capture and first-fault latch
  always_comb begin
    lock_en     = (|fault_q) | lock;
    cap         = (droop_evt | tmo_evt) & {NUMBER_OF_VRM{~lock_en}};
    fault_d     = fault_q;
    fault_tmo_d = fault_tmo_q;
    ffv_d       = ffv_q;
    ffi_d       = ffi_q;
    fft_d       = fft_q;
    found       = 1'b0;

    if (fault_clear) begin
      fault_d     = '0;
      fault_tmo_d = '0;
      ffv_d       = 1'b0;
      ffi_d       = '0;
      fft_d       = 1'b0;
    end else begin
      fault_d     = fault_q | cap;
      // Timeout takes precedence when both events hit a rail together.
      fault_tmo_d = (fault_tmo_q & ~cap) | (tmo_evt & cap);
      if (!ffv_q && (|cap)) begin
        ffv_d = 1'b1;
        for (int unsigned i = 0; i < NUMBER_OF_VRM; i++) begin
          if (cap[i] && !found) begin
            found = 1'b1;
            ffi_d = IDX_W'(i);
            fft_d = tmo_evt[i];
          end
        end
      end
    end

    any_d = |fault_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_q       <= '0;
      fault_q     <= '0;
      fault_tmo_q <= '0;
      any_q       <= 1'b0;
      ffv_q       <= 1'b0;
      ffi_q       <= '0;
      fft_q       <= 1'b0;
      for (int unsigned i = 0; i < NUMBER_OF_VRM; i++) begin
        st_q[i]     <= ST_IDLE;
        lowcnt_q[i] <= '0;
        tmr_q[i]    <= '0;
      end
    end else begin
      chk_q       <= chk_d;
      fault_q     <= fault_d;
      fault_tmo_q <= fault_tmo_d;
      any_q       <= any_d;
      ffv_q       <= ffv_d;
      ffi_q       <= ffi_d;
      fft_q       <= fft_d;
      for (int unsigned i = 0; i < NUMBER_OF_VRM; i++) begin
        st_q[i]     <= st_d[i];
        lowcnt_q[i] <= lowcnt_d[i];
        tmr_q[i]    <= tmr_d[i];
      end
    end
  end

  assign vrm_fault         = fault_q;
  assign vrm_fault_tmo     = fault_tmo_q;
  assign any_vrm_fault     = any_q;
  assign first_fault_valid = ffv_q;
  assign first_fault_idx   = ffi_q;
  assign first_fault_tmo   = fft_q;

endmodule
